// File: rtl/rocketcpu_wb_interconnect.sv
// rocketcpu_wb_interconnect
//
// Wishbone interconnect with one master and NSLAVES slaves. The master's
// merged bus is decoded against per-slave BASE/MASK pairs. The lowest
// matching slave index wins and is registered as the bus enters ACTIVE.
// The block also provides:
//   - per-slave auto-ack for slaves that have no ack output
//   - a watchdog that ends a stalled ACTIVE transfer with an error ack
//   - error responses for unmapped addresses
//   - a sticky fault register that captures the cause and address of the
//     first fault
//
// Ports:
//   i_wb_clk, reset           clock; synchronous active-high reset
//   i_wb_adr/dat/sel/we/cyc   master request
//   o_wb_rdt/ack/err          master response; err is only asserted with ack
//   o_s_adr/dat/sel/we        broadcast to all slaves, combinational pass-through
//   o_s_cyc                   one-hot cycle strobe to the selected slave
//   i_s_rdt, i_s_ack          flattened slave read data (32 bits per slave)
//                             and per-slave acks
//   o_fault_valid/cause/adr   sticky fault record; cause 01 unmapped,
//                             10 timeout
//   i_fault_clr               clears the fault record
module rocketcpu_wb_interconnect #(
    parameter int                    NSLAVES  = 8,
    parameter logic [NSLAVES*32-1:0] BASE     = {NSLAVES{32'h0}},
    parameter logic [NSLAVES*32-1:0] MASK     = {NSLAVES{32'hFFFF_FFFF}},
    parameter logic [NSLAVES-1:0]    AUTOACK  = {NSLAVES{1'b0}},
    parameter int                    TIMEOUT  = 255,
    parameter logic [31:0]           ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    i_wb_clk,
    input  logic                    reset,
    input  logic [31:0]             i_wb_adr,
    input  logic [31:0]             i_wb_dat,
    input  logic [3:0]              i_wb_sel,
    input  logic                    i_wb_we,
    input  logic                    i_wb_cyc,
    output logic [31:0]             o_wb_rdt,
    output logic                    o_wb_ack,
    output logic                    o_wb_err,
    output logic [31:0]             o_s_adr,
    output logic [31:0]             o_s_dat,
    output logic [3:0]              o_s_sel,
    output logic                    o_s_we,
    output logic [NSLAVES-1:0]      o_s_cyc,
    input  logic [NSLAVES*32-1:0]   i_s_rdt,
    input  logic [NSLAVES-1:0]      i_s_ack,
    output logic                    o_fault_valid,
    output logic [1:0]              o_fault_cause,
    output logic [31:0]             o_fault_adr,
    input  logic                    i_fault_clr
);

    localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    // A watchdog of 0 is disabled. The counter still needs at least one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_ERR,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            fault_valid_reg, fault_valid_next;
    logic [1:0]      fault_cause_reg, fault_cause_next;
    logic [31:0]     fault_adr_reg, fault_adr_next;

    logic [NSLAVES-1:0] match;
    logic [31:0]        s_rdt [NSLAVES];
    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               slave_ack;
    logic               timeout_hit;
    logic               fault_event;
    logic [1:0]         fault_event_cause;

    // The broadcast buses go straight through. Only cyc is steered.
    assign o_s_adr = i_wb_adr;
    assign o_s_dat = i_wb_dat;
    assign o_s_sel = i_wb_sel;
    assign o_s_we  = i_wb_we;

    // Per-slave address compare and read-data unpacking.
    generate
        for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_slave
            assign match[gi] = ((i_wb_adr & MASK[32*gi +: 32]) ==
                                (BASE[32*gi +: 32] & MASK[32*gi +: 32]));
            assign s_rdt[gi] = i_s_rdt[32*gi +: 32];
        end
    endgenerate

    // Priority encoder. The loop scans downwards, so the lowest match is
    // assigned last and wins.
    always_comb begin
        hit     = |match;
        hit_idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = IW'(i);
            end
        end
    end

    // Auto-ack slaves ack in their first ACTIVE cycle.
    assign slave_ack   = AUTOACK[idx_reg] | i_s_ack[idx_reg];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TIMEOUT_CNT);

    // Next-state logic and bus outputs.
    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        cnt_next          = cnt_reg;
        o_s_cyc           = '0;
        o_wb_ack          = 1'b0;
        o_wb_err          = 1'b0;
        o_wb_rdt          = '0;
        fault_event       = 1'b0;
        fault_event_cause = 2'b00;

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (i_wb_cyc) begin
                    if (hit) begin
                        idx_next   = hit_idx;
                        state_next = S_ACTIVE;
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end

            S_ACTIVE: begin
                if (!i_wb_cyc) begin
                    // The master aborted. Drop the transfer without an ack
                    // and without recording a fault.
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else if (timeout_hit) begin
                    // The slave's cyc is withdrawn in the same cycle as the
                    // error ack, so a late slave ack cannot be confused with
                    // the next transfer.
                    o_wb_ack          = 1'b1;
                    o_wb_err          = 1'b1;
                    o_wb_rdt          = ERR_DATA;
                    fault_event       = 1'b1;
                    fault_event_cause = CAUSE_TIMEOUT;
                    state_next        = S_DONE;
                end else begin
                    o_s_cyc = NSLAVES'(1'b1) << idx_reg;
                    if (slave_ack) begin
                        o_wb_ack   = 1'b1;
                        o_wb_rdt   = s_rdt[idx_reg];
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            S_ERR: begin
                o_wb_ack          = 1'b1;
                o_wb_err          = 1'b1;
                o_wb_rdt          = ERR_DATA;
                fault_event       = 1'b1;
                fault_event_cause = CAUSE_UNMAPPED;
                state_next        = S_DONE;
            end

            S_DONE: begin
                // A dead cycle that gives the master time to drop cyc
                // before the next decode.
                cnt_next   = '0;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Fault record. A clear in the same cycle as a new fault lets the new
    // fault through. Otherwise the first fault is kept until it is cleared.
    always_comb begin
        fault_valid_next = fault_valid_reg;
        fault_cause_next = fault_cause_reg;
        fault_adr_next   = fault_adr_reg;
        if (i_fault_clr) begin
            fault_valid_next = 1'b0;
            fault_cause_next = 2'b00;
            fault_adr_next   = '0;
        end
        if (fault_event && (!fault_valid_reg || i_fault_clr)) begin
            fault_valid_next = 1'b1;
            fault_cause_next = fault_event_cause;
            fault_adr_next   = i_wb_adr;
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            cnt_reg         <= '0;
            fault_valid_reg <= 1'b0;
            fault_cause_reg <= 2'b00;
            fault_adr_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            cnt_reg         <= cnt_next;
            fault_valid_reg <= fault_valid_next;
            fault_cause_reg <= fault_cause_next;
            fault_adr_reg   <= fault_adr_next;
        end
    end

    assign o_fault_valid = fault_valid_reg;
    assign o_fault_cause = fault_cause_reg;
    assign o_fault_adr   = fault_adr_reg;

endmodule

// File: tb/tb_rocketcpu_wb_interconnect.sv
// Testbench for rocketcpu_wb_interconnect.
// Slave map:
//   0 RAM    (0x0000_0000/FFFF_8000)
//   1        (0x0800_0000/FFFF_0000)
//   2 auto   (0x0500_0000)
//   3        (0x0800_0000/FF00_0000), overlaps slave 1
//   4 dead   (0x0900_0000), never acks
//   5        (0x0B00_0000), variable latency
// The watchdog is set to 16 cycles.
module tb_rocketcpu_wb_interconnect;

    localparam int NS = 6;
    localparam int TO = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [NS*32-1:0] P_BASE = {32'h0B00_0000, 32'h0900_0000, 32'h0800_0000,
                                           32'h0500_0000, 32'h0800_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] P_MASK = {32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000,
                                           32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_8000};
    localparam logic [NS-1:0] P_AUTO = 6'b000100;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   wb_adr, wb_dat, wb_rdt;
    logic [3:0]    wb_sel;
    logic          wb_we, wb_cyc, wb_ack, wb_err;
    logic [31:0]   s_adr, s_dat;
    logic [3:0]    s_sel;
    logic          s_we;
    logic [NS-1:0] s_cyc, s_ack;
    logic [NS*32-1:0] s_rdt;
    logic          fault_valid, fault_clr;
    logic [1:0]    fault_cause;
    logic [31:0]   fault_adr;

    int checks = 0;
    int errors = 0;

    // Slave behaviour: slave i acks lat[i] cycles after its cyc rises.
    // A latency of 255 means the slave never acks.
    int          lat  [NS];
    logic [31:0] sdat [NS];
    int          scnt [NS];

    // Reference fault record.
    logic        mv;
    logic [1:0]  mc;
    logic [31:0] ma;

    always #5 clk = ~clk;

    rocketcpu_wb_interconnect #(
        .NSLAVES (NS),
        .BASE    (P_BASE),
        .MASK    (P_MASK),
        .AUTOACK (P_AUTO),
        .TIMEOUT (TO),
        .ERR_DATA(ERRD)
    ) dut (
        .i_wb_clk     (clk),
        .reset        (reset),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat),
        .i_wb_sel     (wb_sel),
        .i_wb_we      (wb_we),
        .i_wb_cyc     (wb_cyc),
        .o_wb_rdt     (wb_rdt),
        .o_wb_ack     (wb_ack),
        .o_wb_err     (wb_err),
        .o_s_adr      (s_adr),
        .o_s_dat      (s_dat),
        .o_s_sel      (s_sel),
        .o_s_we       (s_we),
        .o_s_cyc      (s_cyc),
        .i_s_rdt      (s_rdt),
        .i_s_ack      (s_ack),
        .o_fault_valid(fault_valid),
        .o_fault_cause(fault_cause),
        .o_fault_adr  (fault_adr),
        .i_fault_clr  (fault_clr)
    );

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            scnt[i] <= s_cyc[i] ? scnt[i] + 1 : 0;
        end
    end

    always_comb begin
        s_ack = '0;
        s_rdt = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack[i] = s_cyc[i] && (lat[i] != 255) && (scnt[i] >= lat[i]);
            s_rdt[32*i +: 32] = sdat[i];
        end
    end

    // The lowest slave whose masked base matches the address, or -1 if
    // no slave matches.
    function automatic int model_target(input logic [31:0] adr);
        for (int i = 0; i < NS; i++) begin
            if ((adr & P_MASK[32*i +: 32]) == (P_BASE[32*i +: 32] & P_MASK[32*i +: 32])) begin
                return i;
            end
        end
        return -1;
    endfunction

    // Reference fault record update. A clear anywhere in the transfer is
    // applied first, then a fault is taken if the record is empty.
    task automatic model_fault(input bit fault, input logic [1:0] cause,
                               input logic [31:0] adr, input bit clr);
        if (clr) begin
            mv = 1'b0; mc = 2'b00; ma = 32'h0;
        end
        if (fault && !mv) begin
            mv = 1'b1; mc = cause; ma = adr;
        end
    endtask

    // Runs one master transfer and reports what was observed. Cycle 0 is the
    // cycle in which cyc is first presented. i_fault_clr pulses in cycle
    // clr_at when clr_at is positive.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input int clr_at,
                           output int ack_cyc, output logic [31:0] rdt_a, output logic err_a,
                           output logic [NS-1:0] scyc_a, output logic [NS-1:0] pre_or,
                           output logic [NS-1:0] pre_and, output int leak,
                           output logic done_busy);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = 4'hF;
        ack_cyc = -1; rdt_a = '0; err_a = 1'b0; scyc_a = '0;
        pre_or = '0; pre_and = '1; leak = 0;
        for (int n = 1; n <= 40 && ack_cyc < 0; n++) begin
            @(posedge clk); #1;
            fault_clr = (n == clr_at);
            @(negedge clk);
            if (wb_ack) begin
                ack_cyc = n; rdt_a = wb_rdt; err_a = wb_err; scyc_a = s_cyc;
            end else begin
                pre_or  = pre_or | s_cyc;
                pre_and = pre_and & s_cyc;
                if (wb_rdt != 0 || wb_err) leak++;
            end
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_we = 1'b0; fault_clr = 1'b0;
        @(negedge clk);
        done_busy = wb_ack || (s_cyc != '0);
        if (wb_rdt != 0 || wb_err) leak++;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_cyc = 1'b1; wb_adr = 32'h0500_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (s_cyc !== '0) begin errors++; $display("FAIL reset_scyc: got %b expected 0", s_cyc); end
        checks++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL reset_ack: got ack=%b err=%b expected 0/0", wb_ack, wb_err); end
        checks++; if (wb_rdt !== 32'h0) begin errors++; $display("FAIL reset_rdt: got %h expected 0", wb_rdt); end
        checks++; if ({fault_valid, fault_cause, fault_adr} !== 35'h0) begin errors++; $display("FAIL reset_fault: got v=%b c=%b a=%h expected 0", fault_valid, fault_cause, fault_adr); end
        @(posedge clk); #1;
        reset = 1'b0; wb_cyc = 1'b0;
        mv = 1'b0; mc = 2'b00; ma = 32'h0;
    endtask

    task automatic test_ram_read();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        lat[0] = 1; sdat[0] = 32'h1234_5678;
        run_txn(32'h0000_0010, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        checks++; if (ac !== 2) begin errors++; $display("FAIL ram_latency: got %0d expected 2", ac); end
        checks++; if (r !== 32'h1234_5678 || e !== 1'b0) begin errors++; $display("FAIL ram_data: got %h err=%b expected 12345678 err=0", r, e); end
        checks++; if (po !== 6'b000001 || sa !== 6'b000001) begin errors++; $display("FAIL ram_scyc: got pre=%b ack=%b expected 000001", po, sa); end
        checks++; if (db !== 1'b0 || lk !== 0) begin errors++; $display("FAIL ram_done: got busy=%b leak=%0d expected 0/0", db, lk); end
    endtask

    task automatic test_autoack();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        sdat[2] = $urandom;
        run_txn(32'h0500_0000, 1'b1, 32'h1, -1, ac, r, e, sa, po, pa, lk, db);
        checks++; if (ac !== 1) begin errors++; $display("FAIL auto_latency: got %0d expected 1", ac); end
        checks++; if (sa !== 6'b000100 || e !== 1'b0) begin errors++; $display("FAIL auto_scyc: got %b err=%b expected 000100 err=0", sa, e); end
        checks++; if (r !== sdat[2]) begin errors++; $display("FAIL auto_rdt: got %h expected %h", r, sdat[2]); end
    endtask

    task automatic test_unmapped();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        run_txn(32'h0600_0000, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        model_fault(1'b1, 2'b01, 32'h0600_0000, 1'b0);
        checks++; if (ac !== 1 || e !== 1'b1) begin errors++; $display("FAIL unmap_ack: got cyc=%0d err=%b expected 1/1", ac, e); end
        checks++; if (r !== ERRD || sa !== '0) begin errors++; $display("FAIL unmap_rdt: got %h scyc=%b expected deadbeef/0", r, sa); end
        checks++; if ({fault_valid, fault_cause, fault_adr} !== {1'b1, 2'b01, 32'h0600_0000}) begin errors++; $display("FAIL unmap_fault: got v=%b c=%b a=%h expected 1/01/06000000", fault_valid, fault_cause, fault_adr); end
        run_txn(32'h0700_0000, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        model_fault(1'b1, 2'b01, 32'h0700_0000, 1'b0);
        checks++; if (ac !== 1 || e !== 1'b1) begin errors++; $display("FAIL unmap2_ack: got cyc=%0d err=%b expected 1/1", ac, e); end
        checks++; if (fault_adr !== 32'h0600_0000) begin errors++; $display("FAIL unmap2_sticky: got %h expected 06000000", fault_adr); end
    endtask

    task automatic test_timeout();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        lat[4] = 255;
        run_txn(32'h0900_0040, 1'b0, 32'h0, TO + 1, ac, r, e, sa, po, pa, lk, db);
        model_fault(1'b1, 2'b10, 32'h0900_0040, 1'b1);
        checks++; if (ac !== TO + 1 || e !== 1'b1 || r !== ERRD) begin errors++; $display("FAIL tmo_ack: got cyc=%0d err=%b rdt=%h expected %0d/1/deadbeef", ac, e, r, TO + 1); end
        checks++; if (sa !== '0 || pa !== 6'b010000) begin errors++; $display("FAIL tmo_scyc: got ack=%b pre=%b expected 0/010000", sa, pa); end
        checks++; if ({fault_valid, fault_cause, fault_adr} !== {1'b1, 2'b10, 32'h0900_0040}) begin errors++; $display("FAIL tmo_clr_fault: got v=%b c=%b a=%h expected 1/10/09000040", fault_valid, fault_cause, fault_adr); end
        checks++; if (db !== 1'b0 || lk !== 0) begin errors++; $display("FAIL tmo_done: got busy=%b leak=%0d expected 0/0", db, lk); end
    endtask

    task automatic test_overlap();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        lat[1] = 2; lat[3] = 0; sdat[1] = $urandom; sdat[3] = ~sdat[1];
        run_txn(32'h0800_0004, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        checks++; if (po !== 6'b000010 || sa !== 6'b000010) begin errors++; $display("FAIL overlap_scyc: got pre=%b ack=%b expected 000010", po, sa); end
        checks++; if (ac !== 3 || r !== sdat[1]) begin errors++; $display("FAIL overlap_ack: got cyc=%0d rdt=%h expected 3/%h", ac, r, sdat[1]); end
    endtask

    task automatic test_abort();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_adr = 32'h0900_0000; wb_we = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++; if (s_cyc !== 6'b010000) begin errors++; $display("FAIL abort_active: got %b expected 010000", s_cyc); end
        @(posedge clk); #1; wb_cyc = 1'b0;
        @(negedge clk);
        checks++; if (wb_ack !== 1'b0 || s_cyc !== '0) begin errors++; $display("FAIL abort_noack: got ack=%b scyc=%b expected 0/0", wb_ack, s_cyc); end
        // Return to IDLE (not DONE) shows up as a one-cycle auto-ack.
        run_txn(32'h0500_0100, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        checks++; if (ac !== 1) begin errors++; $display("FAIL abort_idle: got %0d expected 1", ac); end
        checks++; if ({fault_valid, fault_cause, fault_adr} !== {mv, mc, ma}) begin errors++; $display("FAIL abort_fault: got v=%b c=%b a=%h expected %b/%b/%h", fault_valid, fault_cause, fault_adr, mv, mc, ma); end
        // A cleared counter means a full watchdog period again.
        run_txn(32'h0900_0000, 1'b0, 32'h0, -1, ac, r, e, sa, po, pa, lk, db);
        model_fault(1'b1, 2'b10, 32'h0900_0000, 1'b0);
        checks++; if (ac !== TO + 1) begin errors++; $display("FAIL abort_counter: got %0d expected %0d", ac, TO + 1); end
    endtask

    task automatic test_reset_mid();
        int ac, lk; logic [31:0] r; logic e, db; logic [NS-1:0] sa, po, pa;
        run_txn(32'h0600_0010, 1'b0, 32'h0, 1, ac, r, e, sa, po, pa, lk, db);
        model_fault(1'b1, 2'b01, 32'h0600_0010, 1'b1);
        checks++; if ({fault_valid, fault_adr} !== {1'b1, 32'h0600_0010}) begin errors++; $display("FAIL premid_fault: got v=%b a=%h expected 1/06000010", fault_valid, fault_adr); end
        lat[5] = 4;
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_adr = 32'h0B00_0000;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (s_cyc !== '0 || wb_ack !== 1'b0) begin errors++; $display("FAIL mid_reset_bus: got scyc=%b ack=%b expected 0/0", s_cyc, wb_ack); end
        checks++; if ({fault_valid, fault_cause, fault_adr} !== 35'h0) begin errors++; $display("FAIL mid_reset_fault: got v=%b c=%b a=%h expected 0", fault_valid, fault_cause, fault_adr); end
        @(posedge clk); #1; reset = 1'b0; wb_cyc = 1'b0;
        mv = 1'b0; mc = 2'b00; ma = 32'h0;
    endtask

    task automatic test_back_to_back();
        int ac, lk, t, el, clr_at, sel; logic [31:0] r, er, adr; logic e, ee, db, fault;
        logic [NS-1:0] sa, po, pa, es; logic [1:0] fc;
        for (int it = 0; it < 80; it++) begin
            lat[0] = $urandom_range(0, 4); lat[1] = $urandom_range(0, 4);
            lat[3] = $urandom_range(0, 4); lat[4] = 255;
            lat[5] = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 20);
            for (int i = 0; i < NS; i++) sdat[i] = $urandom;
            sel = $urandom_range(0, 6);
            case (sel)
                0: adr = {17'h0, 13'($urandom), 2'b00};
                1: adr = {16'h0800, 16'($urandom)};
                2: adr = {8'h05, 24'($urandom)};
                3: adr = {8'h08, 8'($urandom_range(1, 255)), 16'($urandom)};
                4: adr = {8'h09, 24'($urandom)};
                5: adr = {8'h0B, 24'($urandom)};
                default: adr = $urandom;
            endcase
            t = model_target(adr);
            fault = 1'b0; fc = 2'b00; es = '0; ee = 1'b0; er = ERRD; el = 1;
            if (t < 0) begin
                ee = 1'b1; fault = 1'b1; fc = 2'b01;
            end else if (P_AUTO[t]) begin
                er = sdat[t]; es = NS'(1) << t;
            end else if (lat[t] < TO) begin
                el = lat[t] + 1; er = sdat[t]; es = NS'(1) << t;
            end else begin
                el = TO + 1; ee = 1'b1; fault = 1'b1; fc = 2'b10;
            end
            case ($urandom_range(0, 3))
                0: clr_at = el;
                1: clr_at = 1;
                default: clr_at = -1;
            endcase
            run_txn(adr, 1'($urandom), $urandom, clr_at, ac, r, e, sa, po, pa, lk, db);
            model_fault(fault, fc, adr, clr_at > 0);
            checks++; if (ac !== el || e !== ee || r !== er) begin errors++; $display("FAIL rnd%0d_resp adr=%h: got cyc=%0d err=%b rdt=%h expected %0d/%b/%h", it, adr, ac, e, r, el, ee, er); end
            checks++; if (sa !== es || lk !== 0 || db !== 1'b0) begin errors++; $display("FAIL rnd%0d_bus adr=%h: got scyc=%b leak=%0d busy=%b expected %b/0/0", it, adr, sa, lk, db, es); end
            if (el > 1) begin
                checks++; if (po !== (NS'(1) << t) || pa !== (NS'(1) << t)) begin errors++; $display("FAIL rnd%0d_pre adr=%h: got or=%b and=%b expected %b", it, adr, po, pa, NS'(1) << t); end
            end
            checks++; if ({fault_valid, fault_cause, fault_adr} !== {mv, mc, ma}) begin errors++; $display("FAIL rnd%0d_fault: got v=%b c=%b a=%h expected %b/%b/%h", it, fault_valid, fault_cause, fault_adr, mv, mc, ma); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0;
        fault_clr = 1'b0;
        for (int i = 0; i < NS; i++) begin lat[i] = 1; sdat[i] = 32'h0; end
        test_reset();
        test_ram_read();
        test_autoack();
        test_unmapped();
        test_timeout();
        test_overlap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
